// File: rtl/lut_ff_mux_deser.sv
// Serial-to-parallel capture stage behind the lut_ff_mux cell: assembles the Q stream into
// WIDTH-bit words and queues them in a first-word-fall-through FIFO with a valid/ready output.
module lut_ff_mux_deser #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       q_in,
  input  logic                       q_valid,
  input  logic                       flush,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow,
  output logic [7:0]                 words_dropped
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] sreg_q, sreg_d, shifted, push_word;
  logic [CW-1:0]    bcnt_q, bcnt_d;
  logic [CW:0]      cnt_abs, pad;
  logic             push;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [PW:0]      level_q, level_d;
  logic             valid_q;
  logic             overflow_q;
  logic [7:0]       dropped_q;
  logic             full, pop, accept, drop;

  // Word assembly: absorb the valid bit first, then decide completion or flush.
  always_comb begin
    shifted = sreg_q;
    if (q_valid) begin
      if (MSB_FIRST != 0) shifted = {sreg_q[WIDTH-2:0], q_in};
      else                shifted = {q_in, sreg_q[WIDTH-1:1]};
    end
    cnt_abs   = {1'b0, bcnt_q} + {{CW{1'b0}}, q_valid};
    pad       = (CW+1)'(WIDTH) - cnt_abs;
    push      = 1'b0;
    push_word = shifted;
    sreg_d    = shifted;
    bcnt_d    = cnt_abs[CW-1:0];
    if (q_valid && (bcnt_q == CW'(WIDTH - 1))) begin
      push   = 1'b1;
      sreg_d = '0;
      bcnt_d = '0;
    end else if (flush && (cnt_abs != '0)) begin
      push = 1'b1;
      // Padding zeros equals shifting the partial word into its final position.
      if (MSB_FIRST != 0) push_word = shifted << pad;
      else                push_word = shifted >> pad;
      sreg_d = '0;
      bcnt_d = '0;
    end
  end

  always_comb begin
    full    = (level_q == (PW+1)'(DEPTH));
    pop     = valid_q && out_ready;
    accept  = push && (!full || pop);
    drop    = push && full && !pop;
    level_d = level_q + {{PW{1'b0}}, accept} - {{PW{1'b0}}, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q     <= '0;
      bcnt_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      dropped_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      sreg_q  <= sreg_d;
      bcnt_q  <= bcnt_d;
      level_q <= level_d;
      valid_q <= (level_d != '0);
      // When full with a simultaneous pop, wptr equals rptr: the freed head slot takes the tail.
      if (accept) begin
        mem_q[wptr_q] <= push_word;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (drop) begin
        overflow_q <= 1'b1;
        if (dropped_q != 8'hFF) dropped_q <= dropped_q + 8'd1;
      end
    end
  end

  assign out_data      = mem_q[rptr_q];
  assign out_valid     = valid_q;
  assign fifo_level    = level_q;
  assign overflow      = overflow_q;
  assign words_dropped = dropped_q;

endmodule

// File: tb/tb_lut_ff_mux_deser.sv
// Directed bench for lut_ff_mux_deser with default parameters (WIDTH=8, DEPTH=4, MSB_FIRST=1).
module tb_lut_ff_mux_deser;

  logic       clk = 1'b0;
  logic       rst;
  logic       q_in;
  logic       q_valid;
  logic       flush;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] fifo_level;
  logic       overflow;
  logic [7:0] words_dropped;

  int n_checks = 0;
  int n_fail   = 0;

  lut_ff_mux_deser #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .q_in         (q_in),
    .q_valid      (q_valid),
    .flush        (flush),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .words_dropped(words_dropped)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    q_in    = b;
    q_valid = 1'b1;
    tick();
    q_valid = 1'b0;
    q_in    = 1'b0;
  endtask

  // Sends bits [7:8-n] of w, MSB first.
  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 7; i > 7 - n; i--) send_bit(w[i]);
  endtask

  task automatic test_reset();
    rst = 1'b1; q_in = 0; q_valid = 0; flush = 0; out_ready = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0 || overflow !== 1'b0 ||
        words_dropped !== 8'd0 || out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b level=%0d ovf=%b drop=%0d data=%h, required 0 0 0 0 00",
               out_valid, fifo_level, overflow, words_dropped, out_data);
    end
  endtask

  task automatic test_basic_word();
    out_ready = 1'b1;
    send_bits(8'hB2, 7);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_premature: out_valid=%b, required 0", out_valid);
    end
    send_bit(1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hB2 || fifo_level !== 3'd1) begin
      n_fail++;
      $display("FAIL basic_word: valid=%b data=%h level=%0d, required 1 b2 1",
               out_valid, out_data, fifo_level);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
      n_fail++;
      $display("FAIL basic_drain: valid=%b level=%0d, required 0 0", out_valid, fifo_level);
    end
  endtask

  task automatic test_gapped_valid();
    logic [7:0] w;
    w = 8'hB2;
    out_ready = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      send_bit(w[i]);
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL gapped_premature: out_valid=%b, required 0", out_valid);
    end
    send_bit(w[0]);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hB2) begin
      n_fail++;
      $display("FAIL gapped_word: valid=%b data=%h, required 1 b2", out_valid, out_data);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
      n_fail++;
      $display("FAIL gapped_once: valid=%b level=%0d, required 0 0", out_valid, fifo_level);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    // Flush with nothing assembled is a no-op.
    flush = 1'b1; tick(); flush = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
      n_fail++;
      $display("FAIL flush_noop: valid=%b level=%0d, required 0 0", out_valid, fifo_level);
    end
    send_bits(8'hC0, 3);
    flush = 1'b1; tick(); flush = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hC0) begin
      n_fail++;
      $display("FAIL flush_partial: valid=%b data=%h, required 1 c0", out_valid, out_data);
    end
    tick();
    send_bits(8'hFF, 8);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hFF || fifo_level !== 3'd1) begin
      n_fail++;
      $display("FAIL flush_then_ff: valid=%b data=%h level=%0d, required 1 ff 1",
               out_valid, out_data, fifo_level);
    end
    tick();
    // Flush on the completing edge pushes only the completed word.
    send_bits(8'h5A, 7);
    flush = 1'b1; send_bit(1'b0); flush = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A || fifo_level !== 3'd1) begin
      n_fail++;
      $display("FAIL flush_complete: valid=%b data=%h level=%0d, required 1 5a 1",
               out_valid, out_data, fifo_level);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
      n_fail++;
      $display("FAIL flush_complete_single: valid=%b level=%0d, required 0 0",
               out_valid, fifo_level);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp [4];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    out_ready = 1'b0;
    send_bits(8'h11, 8); send_bits(8'h22, 8); send_bits(8'h33, 8);
    send_bits(8'h44, 8); send_bits(8'h55, 8);
    n_checks++;
    if (fifo_level !== 3'd4 || overflow !== 1'b1 || words_dropped !== 8'd1 ||
        out_data !== 8'h11) begin
      n_fail++;
      $display("FAIL overflow_state: level=%0d ovf=%b drop=%0d data=%h, required 4 1 1 11",
               fifo_level, overflow, words_dropped, out_data);
    end
    tick();
    n_checks++;
    if (out_data !== 8'h11 || fifo_level !== 3'd4) begin
      n_fail++;
      $display("FAIL overflow_hold: data=%h level=%0d, required 11 4", out_data, fifo_level);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exp[i]) begin
        n_fail++;
        $display("FAIL drain_%0d: valid=%b data=%h, required 1 %h", i, out_valid, out_data,
                 exp[i]);
      end
      out_ready = 1'b1;
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
      n_fail++;
      $display("FAIL drain_empty: valid=%b level=%0d, required 0 0", out_valid, fifo_level);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [4];
    exp = '{8'hA2, 8'hA3, 8'hA4, 8'h66};
    out_ready = 1'b0;
    send_bits(8'hA1, 8); send_bits(8'hA2, 8); send_bits(8'hA3, 8); send_bits(8'hA4, 8);
    send_bits(8'h66, 7);
    out_ready = 1'b1;
    send_bit(1'b0);
    n_checks++;
    if (fifo_level !== 3'd4 || overflow !== 1'b1 || words_dropped !== 8'd1) begin
      n_fail++;
      $display("FAIL full_push_pop: level=%0d ovf=%b drop=%0d, required 4 1 1",
               fifo_level, overflow, words_dropped);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exp[i]) begin
        n_fail++;
        $display("FAIL b2b_order_%0d: valid=%b data=%h, required 1 %h", i, out_valid,
                 out_data, exp[i]);
      end
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b_empty: valid=%b level=%0d, required 0 0", out_valid, fifo_level);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send_bits(8'h11, 8); send_bits(8'h22, 8);
    send_bits(8'hFF, 5);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0 || overflow !== 1'b0 ||
        words_dropped !== 8'd0 || out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b level=%0d ovf=%b drop=%0d data=%h, required 0 0 0 0 00",
               out_valid, fifo_level, overflow, words_dropped, out_data);
    end
    tick();
    rst = 1'b0;
    tick();
    out_ready = 1'b1;
    send_bits(8'hA5, 8);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || fifo_level !== 3'd1) begin
      n_fail++;
      $display("FAIL post_reset_word: valid=%b data=%h level=%0d, required 1 a5 1",
               out_valid, out_data, fifo_level);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
      n_fail++;
      $display("FAIL post_reset_single: valid=%b level=%0d, required 0 0", out_valid, fifo_level);
    end
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_gapped_valid();
    test_flush();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lut_ff_mux_deser.md
Name: lut_ff_mux_deser

Overview:
Downstream capture stage for the lut_ff_mux benchmark. It consumes the registered single-bit Q stream, qualified by a valid strobe, and assembles it into WIDTH-bit words. Completed words are buffered in a small first-word-fall-through FIFO and presented on a valid/ready output interface. It gives the post-route flow a block with a shift register, counters, a FIFO and a handshake, sitting directly behind the LUT/FF/mux cell.

Parameters:
WIDTH, 8, bits per assembled word (2..32)
DEPTH, 4, FIFO entries (power of 2, 2..16)
MSB_FIRST, 1, 1: first received bit lands in out_data[WIDTH-1]; 0: first received bit lands in out_data[0]

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
q_in  input  1  serial data bit (Q from lut_ff_mux)
q_valid  input  1  q_in is sampled on this edge only when high
flush  input  1  push the partial word, zero-padded
out_data  output  WIDTH  FIFO head word
out_valid  output  1  FIFO not empty
out_ready  input  1  consumer accepts the head word
fifo_level  output  $clog2(DEPTH)+1  number of occupied entries
overflow  output  1  sticky; a completed word was dropped
words_dropped  output  8  saturating count of dropped words

Behaviour:
- Reset (asynchronous, rst=1) clears every output and all internal state to 0: shift register, bit counter, FIFO pointers, fifo_level, overflow, words_dropped, out_valid, out_data.
- Reset asserted mid-word or mid-drain discards the partial bits and all FIFO contents. No word is emitted.
- Bit counter bcnt runs 0..WIDTH-1 and advances only on edges where q_valid=1. Gaps in q_valid are allowed and do not disturb assembly.
- MSB_FIRST=1: shift left, new bit enters at the LSB. MSB_FIRST=0: shift right, new bit enters at the MSB.
- Word completion: the edge on which q_valid=1 and bcnt=WIDTH-1. The assembled word, including that bit, is pushed on the same edge, and bcnt returns to 0.
- Flush: on an edge with flush=1, the q_valid bit (if any) is absorbed first. If bcnt is then nonzero, the partial word is pushed, equal to the value after shifting in zeros for the remaining positions, and bcnt becomes 0.
  - flush with bcnt=0 after absorb is a no-op.
  - flush on a completing edge pushes only the completed word.
- Latency: out_valid rises on the edge that pushes into an empty FIFO. The word is visible on out_data in the following cycle. Output is first-word-fall-through.
- Pop occurs when out_valid=1 and out_ready=1. out_ready while empty is ignored.
- Push and pop on the same edge:
  - Always allowed, including when the FIFO is full.
  - fifo_level is unchanged.
  - Order is preserved.
- Push while full and no pop:
  - The word is dropped and the FIFO is unchanged.
  - overflow is set to 1 and holds until reset.
  - words_dropped increments and saturates at 255.
- Pointers wrap modulo DEPTH. fifo_level ranges 0..DEPTH. Full is fifo_level==DEPTH; empty is fifo_level==0.
- out_data holds its value while out_valid=1 and out_ready=0. When empty, out_data is don't-care; the bench must not check it.
- All outputs are registered or driven directly from registers. There is no combinational path from q_in, q_valid, flush or out_ready to any output.

Test Plan:
- MSB_FIRST=1, out_ready=1, q_valid=1 for 8 cycles with bits 1,0,1,1,0,0,1,0 -> one word 0xB2, out_valid high for 1 cycle, fifo_level returns to 0.
- Same 8 bits with q_valid dropped on every other cycle -> 0xB2 emitted once, 1 cycle after the 8th valid bit.
- 3 valid bits 1,1,0 then flush=1 with q_valid=0 -> 0xC0 pushed. Next 8 bits 0xFF -> 0xFF, confirming bcnt was cleared.
- out_ready=0, push 5 words 0x11,0x22,0x33,0x44,0x55 -> fifo_level=4, overflow=1, words_dropped=1. Then out_ready=1 drains 0x11,0x22,0x33,0x44 in order.
- FIFO full, out_ready=1, word 0x66 completes on the popping edge -> fifo_level stays 4, overflow unchanged, 0x66 appears last.
- Assert rst after 5 bits with 2 words queued -> all outputs 0 immediately (asynchronously). A fresh 8-bit stream 0xA5 afterwards yields exactly 0xA5.
